opt_delta_seq: RTL and testbench

- Sequencer in front of the shared distance datapath.
- Accepts one opt_t move proposal per transaction (2-opt, or-opt, or THR).
- Expands it into a fixed stream of distance_command_t steps, resolving each select (K, KP, KM, L, LP, LM) to a concrete city position with ring wrap.
- Waits out the datapath latency, then returns the signed tour-length delta to the replica controller over a valid/ready handshake.

---
 rtl/opt_delta_seq_pkg.sv | 71 +++++++
 rtl/opt_delta_seq_rom.sv | 58 +++++
 rtl/opt_delta_seq.sv | 180 ++++++++++++++++++
 tb/tb_opt_delta_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/opt_delta_seq_pkg.sv
// Shared replica types for the opt-move delta sequencer: proposal and
// distance-command encodings, sequence lengths and the sequencer state enum.
package opt_delta_seq_pkg;

  localparam int city_num = 30;

  // Move kinds carried in a proposal; the 2-bit encoding is fully used.
  typedef enum logic [1:0] {
    THR = 2'd0,
    TWO = 2'd1,
    OR0 = 2'd2,
    OR1 = 2'd3
  } opt_command_t;

  typedef struct packed {
    opt_command_t command;
    logic [6:0]   k;
    logic [6:0]   l;
  } opt_t;

  // Which tour position a distance command refers to.
  typedef enum logic [2:0] {
    SEL_K  = 3'd0,
    SEL_KP = 3'd1,
    SEL_KM = 3'd2,
    SEL_L  = 3'd3,
    SEL_LP = 3'd4,
    SEL_LM = 3'd5
  } distance_select_t;

  // DNOP latches endpoint A, PLS/MNS accumulate d(A, city), ZERO clears.
  typedef enum logic [1:0] {
    DNOP = 2'd0,
    PLS  = 2'd1,
    MNS  = 2'd2,
    ZERO = 2'd3
  } distance_op_t;

  typedef struct packed {
    distance_select_t select;
    distance_op_t     op;
  } distance_command_t;

  typedef logic signed [17:0] distance_data_t;

  typedef struct packed {
    distance_select_t select;
    distance_op_t     op;
  } seq_step_t;

  localparam logic [3:0] SEQ_LEN_THR = 4'd1;
  localparam logic [3:0] SEQ_LEN_TWO = 4'd9;
  localparam logic [3:0] SEQ_LEN_OR  = 4'd13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } seq_state_t;

  // Number of distance commands emitted for a move kind.
  function automatic logic [3:0] seq_len(input opt_command_t cmd);
    case (cmd)
      TWO:      seq_len = SEQ_LEN_TWO;
      OR0, OR1: seq_len = SEQ_LEN_OR;
      default:  seq_len = SEQ_LEN_THR;
    endcase
  endfunction

endpackage

// File: rtl/opt_delta_seq_rom.sv
// Command-sequence table: maps (move kind, step index) to the distance
// command issued at that step. Purely combinational.
module opt_seq_rom
  import opt_delta_seq_pkg::*;
(
  input  opt_command_t opt_command,
  input  logic [3:0]   step,
  output seq_step_t    step_out
);

  function automatic seq_step_t st(input distance_select_t s, input distance_op_t o);
    st.select = s;
    st.op     = o;
  endfunction

  // Step 0 always clears the accumulator; the edge pairs follow per move kind.
  always_comb begin
    step_out = st(SEL_K, DNOP);
    if (step == 4'd0) begin
      step_out = st(SEL_K, ZERO);
    end else begin
      case (opt_command)
        TWO: begin
          case (step)
            4'd1:    step_out = st(SEL_KM, DNOP);
            4'd2:    step_out = st(SEL_L,  PLS);
            4'd3:    step_out = st(SEL_K,  DNOP);
            4'd4:    step_out = st(SEL_LP, PLS);
            4'd5:    step_out = st(SEL_KM, DNOP);
            4'd6:    step_out = st(SEL_K,  MNS);
            4'd7:    step_out = st(SEL_L,  DNOP);
            4'd8:    step_out = st(SEL_LP, MNS);
            default: step_out = st(SEL_K,  DNOP);
          endcase
        end
        OR0, OR1: begin
          case (step)
            4'd1:    step_out = st(SEL_KM, DNOP);
            4'd2:    step_out = st(SEL_KP, PLS);
            4'd3:    step_out = st(SEL_L,  DNOP);
            4'd4:    step_out = st(SEL_K,  PLS);
            4'd5:    step_out = st(SEL_K,  DNOP);
            4'd6:    step_out = st(SEL_LP, PLS);
            4'd7:    step_out = st(SEL_KM, DNOP);
            4'd8:    step_out = st(SEL_K,  MNS);
            4'd9:    step_out = st(SEL_K,  DNOP);
            4'd10:   step_out = st(SEL_KP, MNS);
            4'd11:   step_out = st(SEL_L,  DNOP);
            4'd12:   step_out = st(SEL_LP, MNS);
            default: step_out = st(SEL_K,  DNOP);
          endcase
        end
        default: step_out = st(SEL_K, DNOP);
      endcase
    end
  end

endmodule

// File: rtl/opt_delta_seq.sv
// Opt-move delta sequencer: accepts a move proposal, streams its distance
// commands with ring-wrapped city positions, waits out the datapath latency
// and returns the accumulated delta over a valid/ready handshake.
// Optional build macro OPT_CHECK_EN: legality check of K/L on accept, with
// a sticky opt_err flag and illegal proposals demoted to THR.
module opt_delta_seq
  import opt_delta_seq_pkg::*;
#(
  parameter int CITY_NUM = city_num,
  parameter int DIST_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        opt_valid,
  output logic        opt_ready,
  input  logic [15:0] opt_in,
  output logic        dcmd_valid,
  output logic [4:0]  dcmd,
  output logic [6:0]  dcmd_city,
  input  logic [17:0] dist_in,
  output logic        delta_valid,
  input  logic        delta_ready,
  output logic [17:0] delta_data,
  output logic        opt_err
);

  localparam logic [6:0] LAST_CITY = 7'(CITY_NUM - 1);
  localparam logic [3:0] LAT       = 4'(DIST_LAT);

  opt_t         prop;
  seq_state_t   state_reg, state_next;
  opt_command_t cmd_reg, cmd_next;
  logic [6:0]   k_reg, k_next;
  logic [6:0]   l_reg, l_next;
  logic [3:0]   step_reg, step_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [17:0]  delta_reg, delta_next;
  logic         illegal;
  seq_step_t    rom_step;

  assign prop = opt_t'(opt_in);

`ifdef OPT_CHECK_EN
  logic err_reg, err_next;

  // Legality of the proposal currently presented on opt_in.
  always_comb begin
    illegal = (prop.k >= 7'(CITY_NUM)) || (prop.l >= 7'(CITY_NUM));
    case (prop.command)
      TWO, OR0: if (prop.k >= prop.l) illegal = 1'b1;
      OR1:      if ({1'b0, prop.k} <= ({1'b0, prop.l} + 8'd1)) illegal = 1'b1;
      default:  ;
    endcase
  end

  assign opt_err = err_reg;
`else
  assign illegal = 1'b0;
  assign opt_err = 1'b0;
`endif

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cmd_reg   <= THR;
      k_reg     <= '0;
      l_reg     <= '0;
      step_reg  <= '0;
      cnt_reg   <= '0;
      delta_reg <= '0;
`ifdef OPT_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      k_reg     <= k_next;
      l_reg     <= l_next;
      step_reg  <= step_next;
      cnt_reg   <= cnt_next;
      delta_reg <= delta_next;
`ifdef OPT_CHECK_EN
      err_reg   <= err_next;
`endif
    end
  end

  // Next-state logic: accept, issue N commands, wait DIST_LAT, hold result.
  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    k_next     = k_reg;
    l_next     = l_reg;
    step_next  = step_reg;
    cnt_next   = cnt_reg;
    delta_next = delta_reg;
`ifdef OPT_CHECK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (opt_valid) begin
          cmd_next   = illegal ? THR : prop.command;
          k_next     = prop.k;
          l_next     = prop.l;
          step_next  = 4'd0;
          state_next = ISSUE;
`ifdef OPT_CHECK_EN
          if (illegal) err_next = 1'b1;
`endif
        end
      end
      ISSUE: begin
        if (step_reg == seq_len(cmd_reg) - 4'd1) begin
          cnt_next   = LAT;
          state_next = WAIT;
        end else begin
          step_next = step_reg + 4'd1;
        end
      end
      WAIT: begin
        // The last wait cycle is the one in which dist_in is valid.
        if (cnt_reg <= 4'd1) begin
          delta_next = dist_in;
          state_next = RESULT;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESULT: begin
        if (delta_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  opt_seq_rom u_rom (
    .opt_command (cmd_reg),
    .step        (step_reg),
    .step_out    (rom_step)
  );

  // Successor / predecessor positions of K (index 0) and L (index 1) on the ring.
  logic [6:0] base_city  [2];
  logic [6:0] plus_city  [2];
  logic [6:0] minus_city [2];

  assign base_city[0] = k_reg;
  assign base_city[1] = l_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ring
    assign plus_city[gi]  = (base_city[gi] == LAST_CITY) ? 7'd0 : base_city[gi] + 7'd1;
    assign minus_city[gi] = (base_city[gi] == 7'd0) ? LAST_CITY : base_city[gi] - 7'd1;
  end

  // Resolve the ROM select to a concrete city; outputs idle at zero.
  always_comb begin
    dcmd      = '0;
    dcmd_city = '0;
    if (state_reg == ISSUE) begin
      dcmd = rom_step;
      case (rom_step.select)
        SEL_K:   dcmd_city = k_reg;
        SEL_KP:  dcmd_city = plus_city[0];
        SEL_KM:  dcmd_city = minus_city[0];
        SEL_L:   dcmd_city = l_reg;
        SEL_LP:  dcmd_city = plus_city[1];
        SEL_LM:  dcmd_city = minus_city[1];
        default: dcmd_city = '0;
      endcase
    end
  end

  assign opt_ready   = rst_n && (state_reg == IDLE);
  assign dcmd_valid  = (state_reg == ISSUE);
  assign delta_valid = (state_reg == RESULT);
  assign delta_data  = delta_reg;

endmodule

// File: tb/tb_opt_delta_seq.sv
// Directed bench for opt_delta_seq (CITY_NUM=30, DIST_LAT=2).
// Cycle 0 is the accept cycle; outputs are sampled on the falling edge.
module tb_opt_delta_seq;
  import opt_delta_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        opt_valid = 1'b0;
  logic        opt_ready;
  logic [15:0] opt_in = '0;
  logic        dcmd_valid;
  logic [4:0]  dcmd;
  logic [6:0]  dcmd_city;
  logic [17:0] dist_in = '0;
  logic        delta_valid;
  logic        delta_ready = 1'b0;
  logic [17:0] delta_data;
  logic        opt_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opt_delta_seq #(.CITY_NUM(30), .DIST_LAT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opt_valid   (opt_valid),
    .opt_ready   (opt_ready),
    .opt_in      (opt_in),
    .dcmd_valid  (dcmd_valid),
    .dcmd        (dcmd),
    .dcmd_city   (dcmd_city),
    .dist_in     (dist_in),
    .delta_valid (delta_valid),
    .delta_ready (delta_ready),
    .delta_data  (delta_data),
    .opt_err     (opt_err)
  );

  // Present a proposal for one cycle (cycle 0); returns in cycle 1.
  task automatic send(input opt_command_t c, input logic [6:0] k, input logic [6:0] l);
    opt_valid = 1'b1;
    opt_in    = {c, k, l};
    $display("txn: proposal cmd=%0d k=%0d l=%0d", c, k, l);
    @(negedge clk);
    opt_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (opt_ready !== 1'b0) begin errors++; $display("FAIL reset_opt_ready got=%b exp=0", opt_ready); end
    checks++; if (dcmd_valid !== 1'b0) begin errors++; $display("FAIL reset_dcmd_valid got=%b exp=0", dcmd_valid); end
    checks++; if (dcmd !== 5'd0) begin errors++; $display("FAIL reset_dcmd got=%h exp=0", dcmd); end
    checks++; if (dcmd_city !== 7'd0) begin errors++; $display("FAIL reset_city got=%0d exp=0", dcmd_city); end
    checks++; if (delta_valid !== 1'b0) begin errors++; $display("FAIL reset_delta_valid got=%b exp=0", delta_valid); end
    checks++; if (delta_data !== 18'd0) begin errors++; $display("FAIL reset_delta_data got=%h exp=0", delta_data); end
    checks++; if (opt_err !== 1'b0) begin errors++; $display("FAIL reset_opt_err got=%b exp=0", opt_err); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (opt_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", opt_ready); end
    $display("txn: reset done");
  endtask

  task automatic test_two();
    logic [4:0] ec [9];
    logic [6:0] ek [9];
    ec = '{{SEL_K, ZERO}, {SEL_KM, DNOP}, {SEL_L, PLS}, {SEL_K, DNOP}, {SEL_LP, PLS},
           {SEL_KM, DNOP}, {SEL_K, MNS}, {SEL_L, DNOP}, {SEL_LP, MNS}};
    ek = '{7'd0, 7'd2, 7'd10, 7'd3, 7'd11, 7'd2, 7'd3, 7'd10, 7'd11};
    dist_in = 18'h00111;
    checks++; if (opt_ready !== 1'b1) begin errors++; $display("FAIL two_ready got=%b exp=1", opt_ready); end
    send(TWO, 7'd3, 7'd10);
    for (int i = 0; i < 9; i++) begin
      checks++; if (dcmd_valid !== 1'b1) begin errors++; $display("FAIL two_valid[%0d] got=%b exp=1", i, dcmd_valid); end
      if (i == 0) begin
        checks++; if (dcmd[1:0] !== ZERO) begin errors++; $display("FAIL two_op[0] got=%h exp=%h", dcmd[1:0], ZERO); end
      end else begin
        checks++; if (dcmd !== ec[i]) begin errors++; $display("FAIL two_dcmd[%0d] got=%h exp=%h", i, dcmd, ec[i]); end
        checks++; if (dcmd_city !== ek[i]) begin errors++; $display("FAIL two_city[%0d] got=%0d exp=%0d", i, dcmd_city, ek[i]); end
      end
      checks++; if (opt_ready !== 1'b0) begin errors++; $display("FAIL two_busy[%0d] got=%b exp=0", i, opt_ready); end
      @(negedge clk);
    end
    // cycle 10
    checks++; if (dcmd_valid !== 1'b0 || delta_valid !== 1'b0) begin errors++; $display("FAIL two_c10 got=%b%b exp=00", dcmd_valid, delta_valid); end
    @(negedge clk);
    // cycle 11: datapath result valid
    dist_in = 18'h3FFE7;
    checks++; if (delta_valid !== 1'b0) begin errors++; $display("FAIL two_c11 got=%b exp=0", delta_valid); end
    @(negedge clk);
    // cycle 12
    dist_in = 18'h0AAAA;
    checks++; if (delta_valid !== 1'b1) begin errors++; $display("FAIL two_dv got=%b exp=1", delta_valid); end
    checks++; if (delta_data !== 18'h3FFE7) begin errors++; $display("FAIL two_data got=%h exp=3ffe7", delta_data); end
    delta_ready = 1'b1;
    @(negedge clk);
    delta_ready = 1'b0;
    checks++; if (delta_valid !== 1'b0 || opt_ready !== 1'b1) begin errors++; $display("FAIL two_done got=%b%b exp=01", delta_valid, opt_ready); end
    $display("txn: TWO delta=%h", delta_data);
  endtask

  task automatic test_or1_wrap();
    logic [4:0] ec [13];
    logic [6:0] ek [13];
    ec = '{{SEL_K, ZERO}, {SEL_KM, DNOP}, {SEL_KP, PLS}, {SEL_L, DNOP}, {SEL_K, PLS},
           {SEL_K, DNOP}, {SEL_LP, PLS}, {SEL_KM, DNOP}, {SEL_K, MNS}, {SEL_K, DNOP},
           {SEL_KP, MNS}, {SEL_L, DNOP}, {SEL_LP, MNS}};
    ek = '{7'd0, 7'd29, 7'd1, 7'd27, 7'd0, 7'd0, 7'd28, 7'd29, 7'd0, 7'd0, 7'd1, 7'd27, 7'd28};
    dist_in = 18'h00777;
    delta_ready = 1'b1;
    send(OR1, 7'd0, 7'd27);
    for (int i = 0; i < 13; i++) begin
      checks++; if (dcmd_valid !== 1'b1) begin errors++; $display("FAIL or1_valid[%0d] got=%b exp=1", i, dcmd_valid); end
      if (i == 0) begin
        checks++; if (dcmd[1:0] !== ZERO) begin errors++; $display("FAIL or1_op[0] got=%h exp=%h", dcmd[1:0], ZERO); end
      end else begin
        checks++; if (dcmd !== ec[i]) begin errors++; $display("FAIL or1_dcmd[%0d] got=%h exp=%h", i, dcmd, ec[i]); end
        checks++; if (dcmd_city !== ek[i]) begin errors++; $display("FAIL or1_city[%0d] got=%0d exp=%0d", i, dcmd_city, ek[i]); end
      end
      @(negedge clk);
    end
    // cycle 14
    checks++; if (dcmd_valid !== 1'b0 || delta_valid !== 1'b0) begin errors++; $display("FAIL or1_c14 got=%b%b exp=00", dcmd_valid, delta_valid); end
    @(negedge clk);
    // cycle 15
    dist_in = 18'h00040;
    @(negedge clk);
    // cycle 16
    dist_in = 18'h00777;
    checks++; if (delta_valid !== 1'b1 || delta_data !== 18'h00040) begin errors++; $display("FAIL or1_result got=%b/%h exp=1/00040", delta_valid, delta_data); end
    @(negedge clk);
    checks++; if (delta_valid !== 1'b0 || opt_ready !== 1'b1) begin errors++; $display("FAIL or1_done got=%b%b exp=01", delta_valid, opt_ready); end
    delta_ready = 1'b0;
    $display("txn: OR1 delta=%h", delta_data);
  endtask

  task automatic test_thr_hold();
    dist_in = 18'h00555;
    send(THR, 7'd5, 7'd9);
    // cycle 1
    checks++; if (dcmd_valid !== 1'b1 || dcmd[1:0] !== ZERO) begin errors++; $display("FAIL thr_zero got=%b/%h exp=1/%h", dcmd_valid, dcmd[1:0], ZERO); end
    @(negedge clk);
    checks++; if (dcmd_valid !== 1'b0) begin errors++; $display("FAIL thr_single got=%b exp=0", dcmd_valid); end
    @(negedge clk);
    dist_in = 18'h01234;  // cycle 3
    @(negedge clk);
    dist_in = 18'h02222;
    for (int i = 0; i < 5; i++) begin
      checks++; if (delta_valid !== 1'b1 || delta_data !== 18'h01234) begin errors++; $display("FAIL thr_hold[%0d] got=%b/%h exp=1/01234", i, delta_valid, delta_data); end
      checks++; if (opt_ready !== 1'b0) begin errors++; $display("FAIL thr_ready[%0d] got=%b exp=0", i, opt_ready); end
      @(negedge clk);
    end
    delta_ready = 1'b1;
    checks++; if (delta_valid !== 1'b1 || opt_ready !== 1'b0) begin errors++; $display("FAIL thr_hs got=%b%b exp=10", delta_valid, opt_ready); end
    @(negedge clk);
    delta_ready = 1'b0;
    checks++; if (delta_valid !== 1'b0 || opt_ready !== 1'b1) begin errors++; $display("FAIL thr_done got=%b%b exp=01", delta_valid, opt_ready); end
    $display("txn: THR delta=%h", delta_data);
  endtask

  task automatic test_reset_midflight();
    delta_ready = 1'b1;
    send(TWO, 7'd3, 7'd10);
    repeat (3) @(negedge clk);
    // cycle 4
    checks++; if (dcmd_valid !== 1'b1) begin errors++; $display("FAIL mid_active got=%b exp=1", dcmd_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (dcmd_valid !== 1'b0 || dcmd !== 5'd0 || opt_ready !== 1'b0) begin errors++; $display("FAIL mid_reset got=%b/%h/%b exp=0/00/0", dcmd_valid, dcmd, opt_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (opt_ready !== 1'b1) begin errors++; $display("FAIL mid_idle got=%b exp=1", opt_ready); end
    for (int i = 0; i < 15; i++) begin
      checks++; if (delta_valid !== 1'b0 || dcmd_valid !== 1'b0) begin errors++; $display("FAIL mid_quiet[%0d] got=%b%b exp=00", i, delta_valid, dcmd_valid); end
      @(negedge clk);
    end
    delta_ready = 1'b0;
    $display("txn: reset during TWO, no delta");
  endtask

  task automatic test_check();
    bit done;
    dist_in = 18'h00000;
`ifdef OPT_CHECK_EN
    send(TWO, 7'd12, 7'd5);
    checks++; if (dcmd_valid !== 1'b1 || dcmd[1:0] !== ZERO) begin errors++; $display("FAIL chk_zero got=%b/%h exp=1/%h", dcmd_valid, dcmd[1:0], ZERO); end
    @(negedge clk);
    checks++; if (dcmd_valid !== 1'b0) begin errors++; $display("FAIL chk_single got=%b exp=0", dcmd_valid); end
    checks++; if (opt_err !== 1'b1) begin errors++; $display("FAIL chk_err got=%b exp=1", opt_err); end
    repeat (2) @(negedge clk);
    checks++; if (delta_valid !== 1'b1 || delta_data !== 18'd0) begin errors++; $display("FAIL chk_result got=%b/%h exp=1/00000", delta_valid, delta_data); end
    delta_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (opt_err !== 1'b1) begin errors++; $display("FAIL chk_sticky got=%b exp=1", opt_err); end
`else
    send(TWO, 7'd12, 7'd5);
    @(negedge clk);
    checks++; if (dcmd_valid !== 1'b1 || dcmd_city !== 7'd11) begin errors++; $display("FAIL nochk_seq got=%b/%0d exp=1/11", dcmd_valid, dcmd_city); end
    checks++; if (opt_err !== 1'b0) begin errors++; $display("FAIL nochk_err got=%b exp=0", opt_err); end
    delta_ready = 1'b1;
`endif
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (opt_ready === 1'b1) done = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!done) begin errors++; $display("FAIL chk_drain got=busy exp=idle"); end
    delta_ready = 1'b0;
    $display("txn: illegal TWO k=12 l=5 handled, opt_err=%b", opt_err);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_two();
    test_or1_wrap();
    test_thr_hold();
    test_reset_midflight();
    test_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
